// File: rtl/cache_ctrl_lru_if.sv
// Request/response bus of the set-associative cache controller.
//   master : request issuer (trace bench) - drives req_*, observes req_ready and resp_*
//   slave  : cache controller             - observes req_*, drives req_ready and resp_*
// Parameters:
//   ADDR_W : byte address width
//   WAY_W  : width of resp_way, max(1, log2(NUM_WAYS)) of the attached controller
interface cache_ctrl_lru_if #(
  parameter int ADDR_W = 32,
  parameter int WAY_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic              resp_evict;
  logic              resp_writeback;
  logic              resp_err;
  logic [WAY_W-1:0]  resp_way;

  modport master (
    output req_valid, req_type, req_addr,
    input  req_ready, resp_valid, resp_hit, resp_evict, resp_writeback, resp_err, resp_way
  );

  modport slave (
    input  req_valid, req_type, req_addr,
    output req_ready, resp_valid, resp_hit, resp_evict, resp_writeback, resp_err, resp_way
  );
endinterface

// File: rtl/cache_ctrl_lru.sv
// Write-back / write-allocate set-associative cache controller model.
// One request (read, write, invalidate) is accepted in IDLE and processed by
// the fixed sequence IDLE -> LOOKUP -> UPDATE -> RESP, so the response pulse
// appears in the third cycle after the accepting edge.
// Replacement: REPL_POLICY=0 true LRU (per-way age), 1 = 1-bit MRU pseudo-LRU.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : req_valid/req_ready/req_type/req_addr, resp_* outcome
//   stats_clear       : zero all statistics counters on the next edge
//   stat_*            : saturating statistics counters (CNT_W bits)
module cache_ctrl_lru #(
  parameter int NUM_SETS    = 32,
  parameter int NUM_WAYS    = 8,
  parameter int LINE_SIZE   = 64,
  parameter int ADDR_W      = 32,
  parameter int REPL_POLICY = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_ctrl_lru_if.slave  bus,
  input  logic             stats_clear,
  output logic [CNT_W-1:0] stat_accesses,
  output logic [CNT_W-1:0] stat_reads,
  output logic [CNT_W-1:0] stat_writes,
  output logic [CNT_W-1:0] stat_invals,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses,
  output logic [CNT_W-1:0] stat_evictions,
  output logic [CNT_W-1:0] stat_writebacks
);
  localparam int OFF_W    = $clog2(LINE_SIZE);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W    = ADDR_W - OFF_W - IDX_BITS;

  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_INVAL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP} state_t;
  state_t state_reg, state_next;

  // Request fields
  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic             accept;
  logic [1:0]       type_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             unused_offset;

  generate
    if (IDX_BITS > 0) begin : g_idx
      assign in_idx = bus.req_addr[OFF_W +: IDX_W];
    end else begin : g_no_idx
      assign in_idx = '0;
    end
  endgenerate
  assign in_tag        = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^bus.req_addr[OFF_W-1:0];
  assign accept        = (state_reg == S_IDLE) && bus.req_valid;

  // Storage: tags live in a RAM (no reset, qualified by valid); the
  // per-line status and policy state are flops so reset can clear them.
  logic [NUM_WAYS*TAG_W-1:0] tag_mem [NUM_SETS];
  logic [NUM_WAYS*TAG_W-1:0] tag_row_reg;
  logic [NUM_WAYS-1:0]       valid_reg [NUM_SETS];
  logic [NUM_WAYS-1:0]       dirty_reg [NUM_SETS];
  logic [NUM_WAYS-1:0]       mru_reg   [NUM_SETS];
  logic [NUM_WAYS*WAY_W-1:0] age_reg   [NUM_SETS];

  // Capture the request; the tag row read is registered so LOOKUP sees it.
  always_ff @(posedge clk) begin
    if (accept) begin
      type_reg    <= bus.req_type;
      tag_reg     <= in_tag;
      idx_reg     <= in_idx;
      tag_row_reg <= tag_mem[in_idx];
    end
  end

  // LOOKUP: parallel compare and victim choice
  logic [NUM_WAYS-1:0]       set_valid, set_dirty, set_mru, match;
  logic [NUM_WAYS*WAY_W-1:0] set_age;
  logic [WAY_W-1:0]          hit_way, inv_way, lru_way, mru_way, victim_way, sel_way;
  logic                      inv_found;

  assign set_valid = valid_reg[idx_reg];
  assign set_dirty = dirty_reg[idx_reg];
  assign set_mru   = mru_reg[idx_reg];
  assign set_age   = age_reg[idx_reg];

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
      assign match[gi] = set_valid[gi] && (tag_row_reg[gi*TAG_W +: TAG_W] == tag_reg);
    end
  endgenerate

  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    lru_way   = '0;
    mru_way   = '0;
    inv_found = 1'b0;
    // Scan downwards so the lowest qualifying index is the one kept.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!set_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (!set_mru[w]) mru_way = WAY_W'(w);
      if (set_age[w*WAY_W +: WAY_W] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim_way = inv_found ? inv_way : ((REPL_POLICY == 0) ? lru_way : mru_way);
    sel_way    = ((|match) || (type_reg == T_INVAL)) ? hit_way : victim_way;
  end

  logic             hit_reg, sel_valid_reg, sel_dirty_reg;
  logic [WAY_W-1:0] way_reg;

  always_ff @(posedge clk) begin
    if (state_reg == S_LOOKUP) begin
      hit_reg       <= |match;
      way_reg       <= sel_way;
      sel_valid_reg <= set_valid[sel_way];
      sel_dirty_reg <= set_dirty[sel_way];
    end
  end

  // UPDATE: outcome decode and policy touch
  logic is_read, is_write, is_inval, is_rw, is_err, upd_evict, upd_wb, in_update;
  assign in_update = (state_reg == S_UPDATE);
  assign is_read   = (type_reg == T_READ);
  assign is_write  = (type_reg == T_WRITE);
  assign is_inval  = (type_reg == T_INVAL);
  assign is_rw     = is_read || is_write;
  assign is_err    = (type_reg == 2'd3);
  assign upd_evict = is_rw && !hit_reg && sel_valid_reg;
  assign upd_wb    = sel_valid_reg && sel_dirty_reg &&
                     ((is_rw && !hit_reg) || (is_inval && hit_reg));

  logic [NUM_WAYS*WAY_W-1:0] age_next;
  logic [NUM_WAYS-1:0]       mru_next;
  logic [WAY_W-1:0]          old_age;

  always_comb begin
    old_age  = set_age[way_reg*WAY_W +: WAY_W];
    age_next = set_age;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == way_reg) begin
        age_next[w*WAY_W +: WAY_W] = '0;
      end else if (set_age[w*WAY_W +: WAY_W] < old_age) begin
        age_next[w*WAY_W +: WAY_W] = set_age[w*WAY_W +: WAY_W] + 1'b1;
      end
    end
    mru_next          = set_mru;
    mru_next[way_reg] = 1'b1;
    if (&mru_next) begin
      mru_next          = '0;
      mru_next[way_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && in_update && is_rw && !hit_reg) begin
      tag_mem[idx_reg][way_reg*TAG_W +: TAG_W] <= tag_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        mru_reg[s]   <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_reg[s][w*WAY_W +: WAY_W] <= WAY_W'(w);
        end
      end
    end else if (in_update) begin
      if (is_rw) begin
        valid_reg[idx_reg][way_reg] <= 1'b1;
        if (is_write) begin
          dirty_reg[idx_reg][way_reg] <= 1'b1;
        end else if (!hit_reg) begin
          dirty_reg[idx_reg][way_reg] <= 1'b0;
        end
        if (REPL_POLICY == 0) begin
          age_reg[idx_reg] <= age_next;
        end else begin
          mru_reg[idx_reg] <= mru_next;
        end
      end else if (is_inval && hit_reg) begin
        valid_reg[idx_reg][way_reg] <= 1'b0;
        dirty_reg[idx_reg][way_reg] <= 1'b0;
      end
    end
  end

  // Response registers, loaded in UPDATE and held through RESP
  logic             resp_hit_reg, resp_evict_reg, resp_wb_reg, resp_err_reg;
  logic [WAY_W-1:0] resp_way_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_hit_reg   <= 1'b0;
      resp_evict_reg <= 1'b0;
      resp_wb_reg    <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_way_reg   <= '0;
    end else if (in_update) begin
      resp_hit_reg   <= hit_reg && !is_err;
      resp_evict_reg <= upd_evict;
      resp_wb_reg    <= upd_wb;
      resp_err_reg   <= is_err;
      resp_way_reg   <= way_reg;
    end
  end

  // Statistics: 0 accesses, 1 reads, 2 writes, 3 invals,
  // 4 hits, 5 misses, 6 evictions, 7 writebacks
  logic [7:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [8];

  assign cnt_inc = {upd_wb, upd_evict, is_rw && !hit_reg, is_rw && hit_reg,
                    is_inval, is_write, is_read, 1'b1};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
          cnt_reg[gi] <= '0;
        end else if (in_update && cnt_inc[gi] && !(&cnt_reg[gi])) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stat_accesses   = cnt_reg[0];
  assign stat_reads      = cnt_reg[1];
  assign stat_writes     = cnt_reg[2];
  assign stat_invals     = cnt_reg[3];
  assign stat_hits       = cnt_reg[4];
  assign stat_misses     = cnt_reg[5];
  assign stat_evictions  = cnt_reg[6];
  assign stat_writebacks = cnt_reg[7];

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.req_valid) state_next = S_LOOKUP;
      S_LOOKUP: state_next = S_UPDATE;
      S_UPDATE: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_reg == S_IDLE);
    bus.resp_valid = (state_reg == S_RESP);
  end

  assign bus.resp_hit       = resp_hit_reg;
  assign bus.resp_evict     = resp_evict_reg;
  assign bus.resp_writeback = resp_wb_reg;
  assign bus.resp_err       = resp_err_reg;
  assign bus.resp_way       = resp_way_reg;
endmodule

// File: tb/tb_cache_ctrl_lru.sv
module tb_cache_ctrl_lru;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_lru_if #(.ADDR_W(32), .WAY_W(1)) bus0 ();
  cache_ctrl_lru_if #(.ADDR_W(32), .WAY_W(1)) bus1 ();

  logic [CNT_W-1:0] a0_acc, a0_rd, a0_wr, a0_inv, a0_hit, a0_mis, a0_evc, a0_wb;
  logic [CNT_W-1:0] a1_acc, a1_rd, a1_wr, a1_inv, a1_hit, a1_mis, a1_evc, a1_wb;

  cache_ctrl_lru #(.NUM_SETS(4), .NUM_WAYS(2), .LINE_SIZE(64), .ADDR_W(32),
                   .REPL_POLICY(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .stats_clear(clr0),
    .stat_accesses(a0_acc), .stat_reads(a0_rd), .stat_writes(a0_wr),
    .stat_invals(a0_inv), .stat_hits(a0_hit), .stat_misses(a0_mis),
    .stat_evictions(a0_evc), .stat_writebacks(a0_wb)
  );

  cache_ctrl_lru #(.NUM_SETS(4), .NUM_WAYS(2), .LINE_SIZE(64), .ADDR_W(32),
                   .REPL_POLICY(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .stats_clear(clr1),
    .stat_accesses(a1_acc), .stat_reads(a1_rd), .stat_writes(a1_wr),
    .stat_invals(a1_inv), .stat_hits(a1_hit), .stat_misses(a1_mis),
    .stat_evictions(a1_evc), .stat_writebacks(a1_wb)
  );

  typedef struct {
    string name;
    logic  hit;
    logic  evict;
    logic  wb;
    logic  err;
    logic  chk_way;
    logic  way;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic h, input logic ev, input logic wb,
                              input logic er, input logic cw, input logic w);
    exp_t e;
    e.name = n; e.hit = h; e.evict = ev; e.wb = wb; e.err = er; e.chk_way = cw; e.way = w;
    return e;
  endfunction

  task automatic check_resp(input string dn, input exp_t e, input logic h, input logic ev,
                            input logic wb, input logic er, input logic w);
    $display("%s %s: hit=%0b evict=%0b wb=%0b err=%0b way=%0d", dn, e.name, h, ev, wb, er, w);
    chk({dn, " ", e.name, " hit"}, 32'(h), 32'(e.hit));
    chk({dn, " ", e.name, " evict"}, 32'(ev), 32'(e.evict));
    chk({dn, " ", e.name, " writeback"}, 32'(wb), 32'(e.wb));
    chk({dn, " ", e.name, " err"}, 32'(er), 32'(e.err));
    if (e.chk_way) chk({dn, " ", e.name, " way"}, 32'(w), 32'(e.way));
  endtask

  // Monitors: pop the scoreboard whenever a response is presented
  always @(negedge clk) begin
    if (!rst && bus0.resp_valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected_resp: got resp_valid=1 expected none");
      end else begin
        check_resp("dut0", q0.pop_front(), bus0.resp_hit, bus0.resp_evict,
                   bus0.resp_writeback, bus0.resp_err, bus0.resp_way);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.resp_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected_resp: got resp_valid=1 expected none");
      end else begin
        check_resp("dut1", q1.pop_front(), bus1.resp_hit, bus1.resp_evict,
                   bus1.resp_writeback, bus1.resp_err, bus1.resp_way);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_type = 2'd0; bus0.req_addr = '0;
    bus1.req_valid = 1'b0; bus1.req_type = 2'd0; bus1.req_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one request, push its expectation, wait (bounded) for its response
  task automatic issue(input int d, input logic [1:0] t, input logic [31:0] a, input exp_t e);
    int   n;
    logic rdy;
    n = 0;
    @(negedge clk);
    rdy = (d == 0) ? bus0.req_ready : bus1.req_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = (d == 0) ? bus0.req_ready : bus1.req_ready;
      n++;
    end
    chk({e.name, " ready_wait"}, 32'(rdy), 32'd1);
    if (d == 0) begin
      bus0.req_valid = 1'b1; bus0.req_type = t; bus0.req_addr = a; q0.push_back(e);
    end else begin
      bus1.req_valid = 1'b1; bus1.req_type = t; bus1.req_addr = a; q1.push_back(e);
    end
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 20);
    chk({e.name, " resp_seen"}, 32'(((d == 0) ? q0.size() : q1.size()) == 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   rv_cnt;
    logic [7:0] mask;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst req_ready", 32'(bus0.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus0.resp_valid), 32'd0);
    chk("rst resp_hit", 32'(bus0.resp_hit), 32'd0);
    chk("rst accesses", 32'(a0_acc), 32'd0);

    // 1: read miss then read hit
    issue(0, 2'd0, 32'h000, mk("t1 rd0", 0, 0, 0, 0, 1, 0));
    issue(0, 2'd0, 32'h000, mk("t1 rd0 again", 1, 0, 0, 0, 1, 0));
    chk("t1 reads", 32'(a0_rd), 32'd2);
    chk("t1 hits", 32'(a0_hit), 32'd1);
    chk("t1 misses", 32'(a0_mis), 32'd1);

    // 2: true LRU victim
    do_reset();
    issue(0, 2'd0, 32'h000, mk("t2 rd000", 0, 0, 0, 0, 1, 0));
    issue(0, 2'd0, 32'h100, mk("t2 rd100", 0, 0, 0, 0, 1, 1));
    issue(0, 2'd0, 32'h000, mk("t2 rd000 hit", 1, 0, 0, 0, 1, 0));
    issue(0, 2'd0, 32'h200, mk("t2 rd200 evict", 0, 1, 0, 0, 1, 1));
    chk("t2 evictions", 32'(a0_evc), 32'd1);

    // 3: dirty eviction
    do_reset();
    issue(0, 2'd1, 32'h000, mk("t3 wr000", 0, 0, 0, 0, 1, 0));
    issue(0, 2'd0, 32'h100, mk("t3 rd100", 0, 0, 0, 0, 1, 1));
    issue(0, 2'd0, 32'h200, mk("t3 rd200 wb", 0, 1, 1, 0, 1, 0));
    chk("t3 writebacks", 32'(a0_wb), 32'd1);
    chk("t3 writes", 32'(a0_wr), 32'd1);

    // 4: invalidate a dirty line
    do_reset();
    issue(0, 2'd1, 32'h040, mk("t4 wr040", 0, 0, 0, 0, 1, 0));
    issue(0, 2'd2, 32'h040, mk("t4 inv040", 1, 0, 1, 0, 1, 0));
    issue(0, 2'd0, 32'h040, mk("t4 rd040", 0, 0, 0, 0, 1, 0));
    chk("t4 invals", 32'(a0_inv), 32'd1);
    chk("t4 misses", 32'(a0_mis), 32'd2);
    chk("t4 hits", 32'(a0_hit), 32'd0);

    // 5: throughput with req_valid held for 8 cycles
    do_reset();
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_type = 2'd0; bus0.req_addr = 32'h000;
    acc = 0;
    mask = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (bus0.req_ready) begin
        acc++;
        if (acc == 1) q0.push_back(mk("t5 first", 0, 0, 0, 0, 1, 0));
        else          q0.push_back(mk("t5 second", 1, 0, 0, 0, 1, 0));
      end
      mask[k] = bus0.resp_valid;
    end
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    chk("t5 accepts", 32'(acc), 32'd2);
    chk("t5 resp_valid cycles", 32'(mask), 32'h88);
    chk("t5 accesses", 32'(a0_acc), 32'd2);

    // 5b: reset during UPDATE aborts the request
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_type = 2'd0; bus0.req_addr = 32'h100;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5 ready after rst", 32'(bus0.req_ready), 32'd1);
    chk("t5 accesses after rst", 32'(a0_acc), 32'd0);
    chk("t5 reads after rst", 32'(a0_rd), 32'd0);
    chk("t5 misses after rst", 32'(a0_mis), 32'd0);
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus0.resp_valid) rv_cnt++;
      @(negedge clk);
    end
    chk("t5 no resp after abort", 32'(rv_cnt), 32'd0);
    chk("t5 accesses stay 0", 32'(a0_acc), 32'd0);

    // 6: MRU pseudo-LRU and reserved type
    do_reset();
    issue(1, 2'd0, 32'h000, mk("t6 rd000", 0, 0, 0, 0, 1, 0));
    issue(1, 2'd0, 32'h100, mk("t6 rd100", 0, 0, 0, 0, 1, 1));
    issue(1, 2'd0, 32'h200, mk("t6 rd200 evict", 0, 1, 0, 0, 1, 0));
    issue(1, 2'd3, 32'h000, mk("t6 reserved", 0, 0, 0, 1, 0, 0));
    chk("t6 accesses", 32'(a1_acc), 32'd4);
    chk("t6 reads", 32'(a1_rd), 32'd3);
    chk("t6 evictions", 32'(a1_evc), 32'd1);

    // stats_clear zeroes counters without touching the array
    @(negedge clk);
    clr1 = 1'b1;
    @(posedge clk);
    #1 clr1 = 1'b0;
    @(negedge clk);
    chk("clr accesses", 32'(a1_acc), 32'd0);
    chk("clr evictions", 32'(a1_evc), 32'd0);
    issue(1, 2'd0, 32'h200, mk("clr rd200 hit", 1, 0, 0, 0, 1, 0));
    chk("clr hits after", 32'(a1_hit), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
